backend_issue_queue: RTL and testbench

//  Parametrised multi-lane instruction buffer between frontend and backend issue stage.

---
 rtl/backend_issue_queue.sv | 139 +++++++++++++
 tb/tb_backend_issue_queue.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/backend_issue_queue.sv
// ---------------------------------------------------------------------------
// backend_issue_queue
//
// Multi-lane circular instruction buffer between the frontend and the backend
// issue stage. Up to WIDTH instructions arrive per cycle with an arbitrary
// valid pattern. Valid lanes are packed in lane order into consecutive slots.
// The oldest WIDTH entries are always presented to the issue logic, which
// reports back how many it consumed from lane 0 upward.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   flush_i      drop every entry (mispredict / exception); beats enq/deq
//   in_data_i    WIDTH lanes of DATA_W, lane 0 is the oldest
//   in_valid_i   per-lane valid, any pattern
//   in_ready_o   registered; a full WIDTH-lane packet fits this cycle
//   out_data_o   WIDTH oldest entries, lane 0 is the head
//   out_valid_o  out_valid_o[k] = (count > k)
//   issue_num_i  entries consumed this cycle, clamped to count
//   count_o      current occupancy
//   stall_o      ~in_ready_o
// ---------------------------------------------------------------------------
module backend_issue_queue #(
   parameter int WIDTH  = 2,
   parameter int DEPTH  = 8,
   parameter int DATA_W = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic [WIDTH*DATA_W-1:0]    in_data_i,
   input  logic [WIDTH-1:0]           in_valid_i,
   output logic                       in_ready_o,
   output logic [WIDTH*DATA_W-1:0]    out_data_o,
   output logic [WIDTH-1:0]           out_valid_o,
   input  logic [$clog2(WIDTH+1)-1:0] issue_num_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       stall_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic              ready_q;
   logic              ready_next;

   logic [CNT_W-1:0]  nin;
   logic [CNT_W-1:0]  nin_acc;
   logic [CNT_W-1:0]  ndeq;
   logic [CNT_W-1:0]  issue_ext;
   logic              enq;
   logic [CNT_W-1:0]  lane_off [WIDTH];

   // Each valid lane lands at tail + (number of valid lanes below it), which
   // squeezes out the holes while preserving lane order.
   always_comb begin
      nin = '0;
      for (int k = 0; k < WIDTH; k++) begin
         lane_off[k] = nin;
         nin         = nin + CNT_W'(in_valid_i[k]);
      end
   end

   // Ready is registered, so a packet offered while ready is guaranteed to fit
   // whole; no partial acceptance logic is needed.
   assign enq       = ready_q & (|in_valid_i) & ~flush_i;
   assign issue_ext = CNT_W'(issue_num_i);
   assign ndeq      = (issue_ext > count) ? count : issue_ext;
   assign nin_acc   = enq ? nin : '0;

   always_comb begin
      count_next = count + nin_acc - ndeq;
      if (flush_i)
         count_next = '0;
   end

   // Derived from next-cycle occupancy only; issue_num_i reaches it through a
   // register, never combinationally to in_ready_o.
   assign ready_next = (CNT_W'(DEPTH) - count_next) >= CNT_W'(WIDTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         ready_q <= 1'b1;
      end else begin
         count   <= count_next;
         ready_q <= ready_next;
         if (flush_i) begin
            head <= '0;
            tail <= '0;
         end else begin
            head <= head + PTR_W'(ndeq);
            if (enq)
               tail <= tail + PTR_W'(nin);
         end
      end
   end

   // Storage has no reset; slots are only observed once count covers them.
   always_ff @(posedge clk) begin
      if (!rst && enq) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (in_valid_i[k])
               mem[tail + PTR_W'(lane_off[k])] <= in_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   always_comb begin
      out_data_o  = '0;
      out_valid_o = '0;
      for (int k = 0; k < WIDTH; k++) begin
         out_data_o[k*DATA_W +: DATA_W] = mem[head + PTR_W'(k)];
         out_valid_o[k]                 = count > CNT_W'(k);
      end
   end

   assign in_ready_o = ready_q;
   assign stall_o    = ~ready_q;
   assign count_o    = count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_issue_le_count: assert (flush_i || (issue_ext <= count));
         a_count_le_depth: assert (count <= CNT_W'(DEPTH));
         a_next_le_depth:  assert ((count + nin_acc) <= CNT_W'(DEPTH));
         a_no_underflow:   assert ((count + nin_acc) >= ndeq);
      end
   end

endmodule

// File: tb/tb_backend_issue_queue.sv
module tb_backend_issue_queue;

   localparam int WIDTH  = 2;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 64;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    flush_i;
   logic [WIDTH*DATA_W-1:0] in_data_i;
   logic [WIDTH-1:0]        in_valid_i;
   logic                    in_ready_o;
   logic [WIDTH*DATA_W-1:0] out_data_o;
   logic [WIDTH-1:0]        out_valid_o;
   logic [1:0]              issue_num_i;
   logic [3:0]              count_o;
   logic                    stall_o;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] sb [$];
   logic              mdl_ready;

   backend_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .issue_num_i (issue_num_i),
      .count_o     (count_o),
      .stall_o     (stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = sb.size();
      chk("count", 64'(count_o), 64'(n));
      chk("in_ready", 64'(in_ready_o), 64'(mdl_ready));
      chk("stall", 64'(stall_o), 64'(!mdl_ready));
      chk("out_valid", 64'(out_valid_o), 64'({n > 1, n > 0}));
      if (n > 0) chk("lane0", out_data_o[DATA_W-1:0], sb[0]);
      if (n > 1) chk("lane1", out_data_o[2*DATA_W-1:DATA_W], sb[1]);
   endtask

   // Drive one cycle, then advance the scoreboard model past the edge.
   task automatic step(input logic r, input logic f, input logic [1:0] v,
                       input logic [63:0] d0, input logic [63:0] d1, input int iss);
      int ndeq;
      rst         = r;
      flush_i     = f;
      in_valid_i  = v;
      in_data_i   = {d1, d0};
      issue_num_i = 2'(iss);
      @(posedge clk);
      #1;
      if (r || f) begin
         sb.delete();
      end else begin
         ndeq = (iss > sb.size()) ? sb.size() : iss;
         repeat (ndeq) void'(sb.pop_front());
         if (mdl_ready && v != 2'b00) begin
            if (v[0]) sb.push_back(d0);
            if (v[1]) sb.push_back(d1);
         end
      end
      mdl_ready = (DEPTH - sb.size()) >= WIDTH;
      check_all();
   endtask

   initial begin
      logic [63:0] seq;
      rst = 1'b1; flush_i = 1'b0; in_valid_i = '0; in_data_i = '0; issue_num_i = '0;
      mdl_ready = 1'b1;

      // Reset held two cycles with a packet offered: nothing enqueued.
      step(1, 0, 2'b11, 64'hA0, 64'hA1, 0);
      step(1, 0, 2'b11, 64'hA0, 64'hA1, 0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_ready", 64'(in_ready_o), 64'd1);

      // Fill to full, then a held packet.
      step(0, 0, 2'b11, 64'hA, 64'hB, 0);
      step(0, 0, 2'b11, 64'hC, 64'hD, 0);
      step(0, 0, 2'b11, 64'hE, 64'hF, 0);
      chk("fill6_ready", 64'(in_ready_o), 64'd1);
      step(0, 0, 2'b11, 64'h10, 64'h11, 0);
      chk("full_count", 64'(count_o), 64'd8);
      chk("full_ready", 64'(in_ready_o), 64'd0);
      step(0, 0, 2'b11, 64'h12, 64'h13, 0);
      chk("held_count", 64'(count_o), 64'd8);
      repeat (4) step(0, 0, 2'b00, 64'h0, 64'h0, 2);
      chk("drained", 64'(count_o), 64'd0);

      // Compaction: only lane 1 valid.
      step(0, 0, 2'b10, 64'hDEAD, 64'h5A5A, 0);
      chk("compact_lane0", out_data_o[DATA_W-1:0], 64'h5A5A);
      chk("compact_valid", 64'(out_valid_o), 64'd1);
      step(0, 0, 2'b01, 64'h77, 64'hDEAD, 1);
      step(0, 0, 2'b00, 64'h0, 64'h0, 1);

      // Streaming across the pointer wrap at steady count 2.
      seq = 64'h100;
      step(0, 0, 2'b11, seq, seq + 1, 0);
      seq += 2;
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 2'b11, seq, seq + 1, 2);
         seq += 2;
      end
      chk("stream_count", 64'(count_o), 64'd2);
      step(0, 0, 2'b00, 64'h0, 64'h0, 2);

      // Partial issue with concurrent enqueue.
      step(0, 0, 2'b11, 64'hA, 64'hB, 0);
      step(0, 0, 2'b01, 64'hC, 64'hDEAD, 0);
      step(0, 0, 2'b11, 64'hD, 64'hE, 1);
      chk("partial_lane0", out_data_o[DATA_W-1:0], 64'hB);
      chk("partial_lane1", out_data_o[2*DATA_W-1:DATA_W], 64'hC);
      chk("partial_count", 64'(count_o), 64'd4);

      // Flush beats a same-cycle enqueue and issue.
      step(0, 0, 2'b01, 64'hF, 64'hDEAD, 0);
      chk("preflush_count", 64'(count_o), 64'd5);
      step(0, 1, 2'b11, 64'hBAD0, 64'hBAD1, 2);
      chk("flush_count", 64'(count_o), 64'd0);
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      chk("flush_ready", 64'(in_ready_o), 64'd1);
      step(0, 0, 2'b11, 64'hD1, 64'hD2, 0);
      chk("postflush_lane0", out_data_o[DATA_W-1:0], 64'hD1);
      step(0, 0, 2'b00, 64'h0, 64'h0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
